// File: rtl/if_prefetch_unit_pkg.sv
// Shared widths, reset PC and the fetch-queue entry layout for the IF prefetch unit.
package if_prefetch_unit_pkg;

    localparam int unsigned PC_WIDTH   = 32;
    localparam int unsigned INST_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [PC_WIDTH-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// Small in-order fetch queue: synchronous push/pop/clear, registered head, no bypass.
module prefetch_fifo
    import if_prefetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          clear,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Entry storage; stale contents behind the pointers are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; clear behaves like a reset of the queue.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_unit.sv
// IF-stage prefetcher: sequential word fetch, credit-limited issue, redirect with exact drop of stale responses.
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  imem_req_valid,
    output logic [PC_WIDTH-1:0]   imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    output logic                  inst_valid_F,
    input  logic                  inst_ready_D,
    output logic [INST_WIDTH-1:0] inst_F,
    output logic [PC_WIDTH-1:0]   PC_F,
    output logic [PC_WIDTH-1:0]   PCplus4_F
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] resp_pc;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       drop_cnt;
    logic [CW-1:0]       count;
    logic                credit_ok;
    logic                req_fire;
    logic                resp_fire;
    logic                push;
    logic                pop;
    fetch_entry_t        push_data;
    fetch_entry_t        head;

    prefetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    // Issue credit, handshake qualification and head presentation.
    always_comb begin
        credit_ok      = ({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(FIFO_DEPTH);
        imem_req_valid = rst_n && !redirect_valid && credit_ok;
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        // responses arriving with nothing outstanding belong to a pre-reset request
        resp_fire      = imem_resp_valid && (outstanding != '0);
        push           = resp_fire && (drop_cnt == '0) && !redirect_valid;
        push_data      = '{inst: imem_resp_data, pc: resp_pc};
        inst_valid_F   = rst_n && (count != '0) && !redirect_valid;
        pop            = inst_valid_F && inst_ready_D;
        inst_F         = rst_n ? head.inst : '0;
        PC_F           = rst_n ? head.pc : '0;
        PCplus4_F      = rst_n ? head.pc + PC_WIDTH'(1) : '0;
    end

    // PC counters, in-flight count and stale-response drop accounting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                // everything still in flight after this cycle is stale
                drop_cnt <= drop_cnt + outstanding - CW'(resp_fire);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_WIDTH'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_WIDTH'(1);
                end
                if (resp_fire && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    // Credit invariant: a response is never pushed into a full queue.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && (count == CW'(FIFO_DEPTH))));
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed self-checking bench for if_prefetch_unit with a fixed-latency in-order memory model.
module tb_if_prefetch_unit;
    import if_prefetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid_F;
    logic        inst_ready_D;
    logic [31:0] inst_F;
    logic [31:0] PC_F;
    logic [31:0] PCplus4_F;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned lat      = 1;

    logic [31:0] q_addr [$];
    int unsigned q_due  [$];
    logic [31:0] got_req [$];

    if_prefetch_unit #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid_F    (inst_valid_F),
        .inst_ready_D    (inst_ready_D),
        .inst_F          (inst_F),
        .PC_F            (PC_F),
        .PCplus4_F       (PCplus4_F)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: record accepted requests, then drive this cycle's memory response.
    task automatic tick();
        #1;
        if (imem_req_valid === 1'b1 && imem_req_ready) begin
            q_addr.push_back(imem_req_addr);
            q_due.push_back(cyc + lat);
            got_req.push_back(imem_req_addr);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mk(q_addr[0]);
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    endtask

    task automatic do_reset();
        imem_req_ready = 1'b0;
        inst_ready_D   = 1'b1;
        redirect_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        got_req.delete();
    endtask

    initial begin
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready_D    = 1'b0;
        @(negedge clk);
        tick();
        tick();

        // reset state
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid_F), 32'd0);
        chk("rst_inst", inst_F, 32'd0);
        chk("rst_pc", PC_F, 32'd0);
        chk("rst_pc1", PCplus4_F, 32'd0);

        // 1: streaming, L=1
        rst_n = 1'b1; imem_req_ready = 1'b1; inst_ready_D = 1'b1; lat = 1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
            chk("t1_req_addr", imem_req_addr, 32'(k));
            if (k >= 2) begin
                chk("t1_valid", 32'(inst_valid_F), 32'd1);
                chk("t1_pc", PC_F, 32'(k - 2));
                chk("t1_pc1", PCplus4_F, 32'(k - 1));
                chk("t1_inst", inst_F, mk(32'(k - 2)));
            end else begin
                chk("t1_valid_early", 32'(inst_valid_F), 32'd0);
            end
            tick();
        end
        do_reset();

        // 2: backpressure fills the queue, then drains in order
        imem_req_ready = 1'b1; inst_ready_D = 1'b0; lat = 1;
        for (int k = 0; k < 6; k++) tick();
        #1;
        chk("t2_nreq", 32'(got_req.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2_req_seq", got_req[i], 32'(i));
        chk("t2_req_stopped", 32'(imem_req_valid), 32'd0);
        chk("t2_head_valid", 32'(inst_valid_F), 32'd1);
        inst_ready_D = 1'b1;
        for (int k = 6; k < 11; k++) begin
            #1;
            chk("t2_valid", 32'(inst_valid_F), 32'd1);
            chk("t2_pc", PC_F, 32'(k - 6));
            if (k == 6) chk("t2_no_req_full", 32'(imem_req_valid), 32'd0);
            if (k == 7) begin
                chk("t2_resume_valid", 32'(imem_req_valid), 32'd1);
                chk("t2_resume_addr", imem_req_addr, 32'd4);
            end
            tick();
        end
        do_reset();

        // 3: L=3, redirect with 3 in flight
        imem_req_ready = 1'b1; inst_ready_D = 1'b1; lat = 3;
        for (int k = 0; k < 3; k++) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        chk("t3_redir_noreq", 32'(imem_req_valid), 32'd0);
        chk("t3_redir_novalid", 32'(inst_valid_F), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t3_req_addr", imem_req_addr, 32'h40);
        for (int k = 4; k < 8; k++) begin
            if (k > 4) #1;
            chk("t3_no_stale", 32'(inst_valid_F), 32'd0);
            tick();
        end
        #1;
        chk("t3_valid", 32'(inst_valid_F), 32'd1);
        chk("t3_pc", PC_F, 32'h40);
        chk("t3_pc1", PCplus4_F, 32'h41);
        chk("t3_inst", inst_F, mk(32'h40));
        tick();
        #1;
        chk("t3_pc_next", PC_F, 32'h41);
        do_reset();

        // 4: redirect alongside response and pending pop, then a second redirect
        imem_req_ready = 1'b1; inst_ready_D = 1'b1; lat = 1;
        for (int k = 0; k < 3; k++) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        chk("t4_r1_resp", 32'(imem_resp_valid), 32'd1);
        chk("t4_r1_novalid", 32'(inst_valid_F), 32'd0);
        tick();
        redirect_pc = 32'h80;
        #1;
        chk("t4_r2_noreq", 32'(imem_req_valid), 32'd0);
        chk("t4_r2_novalid", 32'(inst_valid_F), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t4_req_addr", imem_req_addr, 32'h80);
        chk("t4_novalid5", 32'(inst_valid_F), 32'd0);
        tick();
        #1;
        chk("t4_novalid6", 32'(inst_valid_F), 32'd0);
        tick();
        #1;
        chk("t4_valid", 32'(inst_valid_F), 32'd1);
        chk("t4_pc", PC_F, 32'h80);
        chk("t4_inst", inst_F, mk(32'h80));
        do_reset();

        // 5: reset mid-stream with 2 outstanding
        imem_req_ready = 1'b1; inst_ready_D = 1'b1; lat = 3;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req", 32'(imem_req_valid), 32'd0);
        chk("t5_rst_valid", 32'(inst_valid_F), 32'd0);
        chk("t5_rst_inst", inst_F, 32'd0);
        chk("t5_rst_pc", PC_F, 32'd0);
        chk("t5_rst_pc1", PCplus4_F, 32'd0);
        tick();
        rst_n = 1'b1; imem_req_ready = 1'b0;
        #1;
        chk("t5_late_resp0", 32'(imem_resp_valid), 32'd1);
        chk("t5_restart_valid", 32'(imem_req_valid), 32'd1);
        chk("t5_restart_addr", imem_req_addr, 32'd0);
        chk("t5_novalid3", 32'(inst_valid_F), 32'd0);
        tick();
        #1;
        chk("t5_novalid4", 32'(inst_valid_F), 32'd0);
        tick();
        imem_req_ready = 1'b1;
        #1;
        chk("t5_req_addr", imem_req_addr, 32'd0);
        chk("t5_novalid5", 32'(inst_valid_F), 32'd0);
        tick();
        for (int k = 6; k < 9; k++) begin
            #1;
            chk("t5_novalid", 32'(inst_valid_F), 32'd0);
            tick();
        end
        #1;
        chk("t5_valid", 32'(inst_valid_F), 32'd1);
        chk("t5_pc", PC_F, 32'd0);
        chk("t5_inst", inst_F, mk(32'd0));
        do_reset();

        // 6: PC wrap at the top of the address space
        imem_req_ready = 1'b1; inst_ready_D = 1'b1; lat = 1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t6_req_top", imem_req_addr, 32'hFFFF_FFFF);
        tick();
        #1;
        chk("t6_req_wrap", imem_req_addr, 32'h0);
        tick();
        #1;
        chk("t6_pc_top", PC_F, 32'hFFFF_FFFF);
        chk("t6_pc1_wrap", PCplus4_F, 32'h0);
        tick();
        #1;
        chk("t6_pc_zero", PC_F, 32'h0);
        chk("t6_pc1_one", PCplus4_F, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
